uno_deck_dealer: RTL and testbench

- Card source for all players. Holds the remaining UNO draw pile as per-card counts and serves one random card per draw request.
- Feeds the computer and human player blocks via o_drawn/o_card, and exposes o_idle as their "deck ready" (check) input.
- Accepts played cards back through a discard port so the pile can be refilled.
- Card encoding: [5:4] colour (0 red, 1 yellow, 2 green, 3 blue); [3:0] value (0-9 numbers, 10-12 action cards, 13 wild, 14 wild draw four).

---
 rtl/uno_deck_dealer.sv | 152 +++++++++++++++
 tb/tb_uno_deck_dealer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uno_deck_dealer.sv
// uno_deck_dealer: UNO draw pile held as 54 per-card counters. Each draw request
// picks a random starting slot from an 8-bit LFSR and probes one slot per cycle
// until it finds a slot with a card left. Played cards return through a discard port.
//
// Ports:
//   i_clk           clock
//   i_rst_n         asynchronous reset, active HIGH despite its name
//   i_init          1-cycle pulse: refill the deck and abort any draw in progress
//   i_draw_req      request one card (sampled only while o_idle)
//   o_drawn         1-cycle pulse: o_card is valid
//   o_card          last drawn card {colour[1:0], value[3:0]}
//   o_idle          ready to accept i_draw_req
//   o_empty         pile is empty
//   o_remaining     cards left in the pile, 0..108
//   i_discard_valid return i_discard_card to the pile this cycle
//   i_discard_card  card being returned
module uno_deck_dealer #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_init,
  input  logic       i_draw_req,
  output logic       o_drawn,
  output logic [5:0] o_card,
  output logic       o_idle,
  output logic       o_empty,
  output logic [6:0] o_remaining,
  input  logic       i_discard_valid,
  input  logic [5:0] i_discard_card
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  // Slot layout: colour*13+value for values 0-12, 52 = wild, 53 = wild draw four.
  function automatic logic [2:0] slot_max(input logic [5:0] slot);
    if (slot >= 6'd52) return 3'd4;
    if (slot == 6'd0 || slot == 6'd13 || slot == 6'd26 || slot == 6'd39) return 3'd1;
    return 3'd2;
  endfunction

  state_t     state_q;
  logic [7:0] lfsr_q;
  logic [5:0] idx_q;
  logic [6:0] remaining_q, remaining_d;
  logic [5:0] card_q;
  logic       drawn_q;
  logic [2:0] cnt_q [54];
  logic [2:0] cnt_d [54];

  logic       lfsr_fb;
  logic [5:0] probe_start;
  logic       hit_en;
  logic [5:0] hit_card;
  logic [1:0] hit_colour;
  logic [5:0] d_slot;
  logic       d_ok;
  logic       disc_en;

  // x^8+x^6+x^5+x^4+1, shifting towards the MSB
  assign lfsr_fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign probe_start = (lfsr_q[5:0] >= 6'd54) ? lfsr_q[5:0] - 6'd10 : lfsr_q[5:0];
  assign hit_en      = (state_q == S_SEARCH) && (cnt_q[idx_q] != 3'd0);

  // Slot index back to card code; wilds are reported with colour 0.
  always_comb begin
    hit_colour = 2'd0;
    if (idx_q >= 6'd39)      hit_colour = 2'd3;
    else if (idx_q >= 6'd26) hit_colour = 2'd2;
    else if (idx_q >= 6'd13) hit_colour = 2'd1;
    if (idx_q == 6'd52)      hit_card = 6'b00_1101;
    else if (idx_q == 6'd53) hit_card = 6'b00_1110;
    else hit_card = {hit_colour, 4'(idx_q - 6'(hit_colour) * 6'd13)};
  end

  always_comb begin
    d_slot = 6'd0;
    d_ok   = 1'b0;
    if (i_discard_card[3:0] == 4'd13) begin
      d_slot = 6'd52;
      d_ok   = 1'b1;
    end else if (i_discard_card[3:0] == 4'd14) begin
      d_slot = 6'd53;
      d_ok   = 1'b1;
    end else if (i_discard_card[3:0] <= 4'd12) begin
      d_slot = 6'(i_discard_card[5:4]) * 6'd13 + {2'b00, i_discard_card[3:0]};
      d_ok   = 1'b1;
    end
    disc_en = i_discard_valid && d_ok && (cnt_q[d_slot] < slot_max(d_slot));
  end

  // Discard and hit on the same slot both apply and cancel out.
  always_comb begin
    for (int i = 0; i < 54; i++) begin
      cnt_d[i] = cnt_q[i];
      if (disc_en && d_slot == 6'(i)) cnt_d[i] = cnt_d[i] + 3'd1;
      if (hit_en && idx_q == 6'(i))   cnt_d[i] = cnt_d[i] - 3'd1;
    end
    remaining_d = remaining_q + 7'(disc_en) - 7'(hit_en);
  end

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      idx_q       <= 6'd0;
      remaining_q <= 7'd108;
      card_q      <= 6'd0;
      drawn_q     <= 1'b0;
      for (int i = 0; i < 54; i++) cnt_q[i] <= slot_max(6'(i));
    end else if (i_init) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      idx_q       <= 6'd0;
      remaining_q <= 7'd108;
      card_q      <= 6'd0;
      drawn_q     <= 1'b0;
      for (int i = 0; i < 54; i++) cnt_q[i] <= slot_max(6'(i));
    end else begin
      lfsr_q      <= {lfsr_q[6:0], lfsr_fb};
      remaining_q <= remaining_d;
      for (int i = 0; i < 54; i++) cnt_q[i] <= cnt_d[i];
      drawn_q     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_draw_req && remaining_q != 7'd0) begin
            idx_q   <= probe_start;
            state_q <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (hit_en) begin
            card_q  <= hit_card;
            drawn_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= (idx_q == 6'd53) ? 6'd0 : idx_q + 6'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_drawn     = drawn_q;
  assign o_card      = card_q;
  assign o_idle      = (state_q == S_IDLE);
  assign o_empty     = (remaining_q == 7'd0);
  assign o_remaining = remaining_q;

endmodule

// File: tb/tb_uno_deck_dealer.sv
module tb_uno_deck_dealer;

  logic       clk;
  logic       rst;
  logic       init;
  logic       draw_req;
  logic       drawn;
  logic [5:0] card;
  logic       idle;
  logic       empty;
  logic [6:0] remaining;
  logic       disc_valid;
  logic [5:0] disc_card;

  int n_pass  = 0;
  int n_total = 0;

  uno_deck_dealer #(.LFSR_SEED(8'hA5)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst),
    .i_init         (init),
    .i_draw_req     (draw_req),
    .o_drawn        (drawn),
    .o_card         (card),
    .o_idle         (idle),
    .o_empty        (empty),
    .o_remaining    (remaining),
    .i_discard_valid(disc_valid),
    .i_discard_card (disc_card)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for idle, pulse a request, then wait for o_drawn. lat counts cycles from
  // the request cycle, so a hit on probe n yields lat = 2+n.
  task automatic do_draw(output bit got, output logic [5:0] c, output int lat);
    int k = 0;
    while (!idle && k < 80) begin
      tick();
      k++;
    end
    draw_req = 1'b1;
    tick();
    draw_req = 1'b0;
    lat = 1;
    while (!drawn && lat < 60) begin
      tick();
      lat++;
    end
    got = drawn;
    c   = card;
  endtask

  task automatic discard(input logic [5:0] c);
    disc_valid = 1'b1;
    disc_card  = c;
    tick();
    disc_valid = 1'b0;
  endtask

  task automatic pulse_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_total++;
    if (remaining !== 7'd108) $display("FAIL reset_remaining got %0d want 108", remaining);
    else n_pass++;
    n_total++;
    if (card !== 6'd0 || drawn !== 1'b0) $display("FAIL reset_card got card=%h drawn=%b want 0/0", card, drawn);
    else n_pass++;
    n_total++;
    if (idle !== 1'b1 || empty !== 1'b0) $display("FAIL reset_flags got idle=%b empty=%b want 1/0", idle, empty);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_drain();
    int hist [64];
    int pulses = 0;
    int bad_rem = 0;
    int bad_lat = 0;
    bit got;
    logic [5:0] c;
    int lat;
    logic [5:0] code;
    int want;
    for (int i = 0; i < 64; i++) hist[i] = 0;
    for (int d = 0; d < 108; d++) begin
      do_draw(got, c, lat);
      if (got) begin
        pulses++;
        hist[c]++;
        if (remaining !== 7'(107 - d)) bad_rem++;
        if (lat < 2 || lat > 55) bad_lat++;
      end
    end
    n_total++;
    if (pulses !== 108) $display("FAIL drain_pulses got %0d want 108", pulses);
    else n_pass++;
    n_total++;
    if (bad_rem !== 0) $display("FAIL drain_remaining_steps got %0d bad want 0", bad_rem);
    else n_pass++;
    n_total++;
    if (bad_lat !== 0) $display("FAIL drain_latency got %0d out of range want 0", bad_lat);
    else n_pass++;
    for (int i = 0; i < 64; i++) begin
      code = 6'(i);
      if (code == 6'h0D || code == 6'h0E) want = 4;
      else if (code[3:0] >= 4'd13)         want = 0;
      else if (code[3:0] == 4'd0)          want = 1;
      else                                 want = 2;
      n_total++;
      if (hist[i] !== want) $display("FAIL drain_hist code %h got %0d want %0d", code, hist[i], want);
      else n_pass++;
    end
    tick();
    n_total++;
    if (remaining !== 7'd0 || empty !== 1'b1) $display("FAIL drain_empty got rem=%0d empty=%b want 0/1", remaining, empty);
    else n_pass++;
  endtask

  task automatic test_empty_draw();
    int n_drawn = 0;
    int n_busy = 0;
    draw_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (drawn) n_drawn++;
      if (!idle) n_busy++;
    end
    draw_req = 1'b0;
    n_total++;
    if (n_drawn !== 0) $display("FAIL empty_no_draw got %0d pulses want 0", n_drawn);
    else n_pass++;
    n_total++;
    if (n_busy !== 0) $display("FAIL empty_idle got %0d busy cycles want 0", n_busy);
    else n_pass++;
    n_total++;
    if (remaining !== 7'd0) $display("FAIL empty_remaining got %0d want 0", remaining);
    else n_pass++;
  endtask

  task automatic test_discard_draw();
    bit got;
    logic [5:0] c;
    int lat;
    discard(6'b01_0101);
    n_total++;
    if (remaining !== 7'd1 || empty !== 1'b0) $display("FAIL discard_count got rem=%0d empty=%b want 1/0", remaining, empty);
    else n_pass++;
    do_draw(got, c, lat);
    n_total++;
    if (!got || lat < 2 || lat > 55) $display("FAIL discard_draw_latency got drawn=%b lat=%0d want 1 and 2..55", got, lat);
    else n_pass++;
    n_total++;
    if (c !== 6'b01_0101) $display("FAIL discard_draw_card got %h want 15", c);
    else n_pass++;
    n_total++;
    if (remaining !== 7'd0) $display("FAIL discard_draw_remaining got %0d want 0", remaining);
    else n_pass++;
  endtask

  task automatic test_wild_discard();
    bit got;
    logic [5:0] c;
    int lat;
    discard(6'b10_1101);
    do_draw(got, c, lat);
    n_total++;
    if (!got || c !== 6'b00_1101) $display("FAIL wild_card got drawn=%b card=%h want 1/0d", got, c);
    else n_pass++;
    tick();
    discard(6'b11_1111);
    n_total++;
    if (remaining !== 7'd0) $display("FAIL value15_ignored got %0d want 0", remaining);
    else n_pass++;
  endtask

  task automatic test_full_discard_ignored();
    pulse_init();
    n_total++;
    if (remaining !== 7'd108) $display("FAIL init_refill got %0d want 108", remaining);
    else n_pass++;
    discard(6'b00_0000);
    tick();
    n_total++;
    if (remaining !== 7'd108) $display("FAIL full_slot_discard got %0d want 108", remaining);
    else n_pass++;
  endtask

  task automatic test_init_abort();
    bit got;
    logic [5:0] c;
    int lat;
    int n_drawn = 0;
    for (int d = 0; d < 107; d++) do_draw(got, c, lat);
    tick();
    n_total++;
    if (remaining !== 7'd1) $display("FAIL abort_setup got %0d want 1", remaining);
    else n_pass++;
    draw_req = 1'b1;
    tick();
    draw_req = 1'b0;
    // Now in the first search cycle; init takes priority even over a hit here.
    init = 1'b1;
    tick();
    init = 1'b0;
    if (drawn) n_drawn++;
    n_total++;
    if (idle !== 1'b1) $display("FAIL abort_idle got %b want 1", idle);
    else n_pass++;
    n_total++;
    if (remaining !== 7'd108) $display("FAIL abort_remaining got %0d want 108", remaining);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (drawn) n_drawn++;
    end
    n_total++;
    if (n_drawn !== 0) $display("FAIL abort_no_draw got %0d pulses want 0", n_drawn);
    else n_pass++;
    do_draw(got, c, lat);
    n_total++;
    if (!got || lat < 2 || lat > 55 || remaining !== 7'd107)
      $display("FAIL abort_next_draw got drawn=%b lat=%0d rem=%0d want 1/2..55/107", got, lat, remaining);
    else n_pass++;
  endtask

  initial begin
    rst        = 1'b0;
    init       = 1'b0;
    draw_req   = 1'b0;
    disc_valid = 1'b0;
    disc_card  = 6'd0;
    #2;
    test_reset();
    test_full_drain();
    test_empty_draw();
    test_discard_draw();
    test_wild_discard();
    test_full_discard_ignored();
    test_init_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
